// File: rtl/processor_pkg.sv
// Shared types and widths for the basic processor: opcode and sequencer state encodings.
package processor_pkg;

  localparam int WORD_W = 8;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_BNE   = 3'd6,
    OP_HALT  = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_D = 3'd2,
    DECODE  = 3'd3,
    EXEC    = 3'd4,
    HALTED  = 3'd5
  } state_t;

endpackage

// File: rtl/sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath blocks it steers (slave).
interface sequencer_if;
  import processor_pkg::*;

  logic            start;
  logic [OP_W-1:0] op;
  logic            z_flag;
  logic ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_xnor;
  logic PC_bus, load_PC, INC_PC;
  logic Addr_bus, load_IR, load_MAR;
  logic CS, R_NW;
  logic halted;

  modport master (
    input  start, op, z_flag,
    output ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_xnor,
    output PC_bus, load_PC, INC_PC, Addr_bus, load_IR, load_MAR, CS, R_NW, halted
  );

  modport slave (
    output start, op, z_flag,
    input  ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_xnor,
    input  PC_bus, load_PC, INC_PC, Addr_bus, load_IR, load_MAR, CS, R_NW, halted
  );

endinterface

// File: rtl/sequencer.sv
// Fetch/decode/execute control unit; strobes are a combinational decode of the state register.
//
// state   | meaning
// IDLE    | waiting for start, all strobes low
// FETCH_A | PC -> bus -> MAR, PC incremented
// FETCH_D | RAM read into IR
// DECODE  | IR address field -> MAR; BNE resolves here, HALT leaves
// EXEC    | RAM read into ACC (through ALU) or ACC written to RAM
// HALTED  | parked until reset
module sequencer #(
  parameter int OP_W = processor_pkg::OP_W
) (
  input  logic         clock,
  input  logic         reset,
  sequencer_if.master  bus
);
  import processor_pkg::*;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_raw;
  opcode_t         opc;

  assign op_raw = bus.op;
  assign opc    = opcode_t'(op_raw);

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.ACC_bus  = 1'b0;
    bus.load_ACC = 1'b0;
    bus.ALU_ACC  = 1'b0;
    bus.ALU_add  = 1'b0;
    bus.ALU_sub  = 1'b0;
    bus.ALU_xor  = 1'b0;
    bus.ALU_xnor = 1'b0;
    bus.PC_bus   = 1'b0;
    bus.load_PC  = 1'b0;
    bus.INC_PC   = 1'b0;
    bus.Addr_bus = 1'b0;
    bus.load_IR  = 1'b0;
    bus.load_MAR = 1'b0;
    bus.CS       = 1'b0;
    bus.R_NW     = 1'b0;
    bus.halted   = 1'b0;
    // Reset gates every strobe so a mid-instruction reset can never write RAM or drive the bus.
    if (reset) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) state_d = FETCH_A;
        FETCH_A: begin
          bus.PC_bus   = 1'b1;
          bus.load_MAR = 1'b1;
          bus.INC_PC   = 1'b1;
          bus.load_PC  = 1'b1;
          state_d      = FETCH_D;
        end
        FETCH_D: begin
          bus.CS      = 1'b1;
          bus.R_NW    = 1'b1;
          bus.load_IR = 1'b1;
          state_d     = DECODE;
        end
        DECODE: begin
          bus.Addr_bus = 1'b1;
          bus.load_MAR = 1'b1;
          case (opc)
            OP_BNE: begin
              bus.load_PC = ~bus.z_flag;
              state_d     = FETCH_A;
            end
            OP_HALT: state_d = HALTED;
            default: state_d = EXEC;
          endcase
        end
        EXEC: begin
          state_d = FETCH_A;
          case (opc)
            OP_LOAD: begin
              bus.CS       = 1'b1;
              bus.R_NW     = 1'b1;
              bus.load_ACC = 1'b1;
            end
            OP_STORE: begin
              bus.CS      = 1'b1;
              bus.ACC_bus = 1'b1;
            end
            OP_ADD, OP_SUB, OP_XOR, OP_XNOR: begin
              bus.CS       = 1'b1;
              bus.R_NW     = 1'b1;
              bus.load_ACC = 1'b1;
              bus.ALU_ACC  = 1'b1;
              bus.ALU_add  = (opc == OP_ADD);
              bus.ALU_sub  = (opc == OP_SUB);
              bus.ALU_xor  = (opc == OP_XOR);
              bus.ALU_xnor = (opc == OP_XNOR);
            end
            default: ;
          endcase
        end
        HALTED: bus.halted = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
